// File: rtl/hexa_digits_to_byte.sv
// Hex-entry assembler: shifts keypad digits into an accumulator, echoes them
// for the display and presents a range-checked byte through a valid/ack handshake.
module hexa_digits_to_byte #(
  parameter int MAX_DIGITS = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] digit_in,
  input  logic       digit_valid,
  input  logic       enter,
  input  logic       clear,
  input  logic       byte_ack,
  output logic [7:0] byte_out,
  output logic       byte_valid,
  output logic       overflow,
  output logic [1:0] digit_count,
  output logic [3:0] unidad,
  output logic [3:0] decena,
  output logic [3:0] centena
);

  // state | meaning
  // IDLE  | no digits held, accumulator zero
  // ENTRY | at least one digit held, accepting more
  // HOLD  | committed byte presented, waiting for ack
  typedef enum logic [1:0] {IDLE, ENTRY, HOLD} state_t;

  localparam int AW = 4 * MAX_DIGITS;

  state_t          state, state_nxt;
  logic [AW-1:0]   acc, acc_nxt;
  logic [1:0]      count, count_nxt;
  logic [7:0]      byte_nxt;
  logic            valid_nxt, ovf_nxt;
  logic [AW-1:0]   acc_shift;
  logic            acc_big;

  assign acc_shift = {acc[AW-5:0], digit_in};
  // any bit above the low byte set means the value exceeds 0xFF
  assign acc_big   = |(acc >> 8);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      acc        <= '0;
      count      <= '0;
      byte_out   <= '0;
      byte_valid <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      state      <= state_nxt;
      acc        <= acc_nxt;
      count      <= count_nxt;
      byte_out   <= byte_nxt;
      byte_valid <= valid_nxt;
      overflow   <= ovf_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    acc_nxt   = acc;
    count_nxt = count;
    byte_nxt  = byte_out;
    valid_nxt = byte_valid;
    ovf_nxt   = overflow;
    unique case (state)
      IDLE: begin
        if (clear) begin
          ovf_nxt = 1'b0;
        end else if (enter) begin
          state_nxt = IDLE;
        end else if (digit_valid) begin
          acc_nxt   = acc_shift;
          count_nxt = 2'd1;
          ovf_nxt   = 1'b0;
          state_nxt = ENTRY;
        end
      end
      ENTRY: begin
        if (clear) begin
          acc_nxt   = '0;
          count_nxt = '0;
          ovf_nxt   = 1'b0;
          state_nxt = IDLE;
        end else if (enter) begin
          if (acc_big) begin
            ovf_nxt = 1'b1;
          end else begin
            byte_nxt  = acc[7:0];
            valid_nxt = 1'b1;
            state_nxt = HOLD;
          end
        end else if (digit_valid && (count < 2'(MAX_DIGITS))) begin
          acc_nxt   = acc_shift;
          count_nxt = count + 2'd1;
          ovf_nxt   = 1'b0;
        end
      end
      HOLD: begin
        // clear and ack both release the byte; clear just means it was not delivered
        if (clear || byte_ack) begin
          acc_nxt   = '0;
          count_nxt = '0;
          valid_nxt = 1'b0;
          ovf_nxt   = 1'b0;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign digit_count = count;
  assign unidad      = acc[3:0];
  assign decena      = acc[7:4];

  generate
    if (MAX_DIGITS == 3) begin : g_centena
      assign centena = acc[11:8];
    end else begin : g_no_centena
      assign centena = 4'h0;
    end
  endgenerate

endmodule
